// File: rtl/mc_ctrl_pkg.sv
// Shared control definitions: sequencer states, instruction classes and the
// opcode/funct encodings recognised by the multi-cycle core.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S0   = 3'd1,
      ST_S1   = 3'd2,
      ST_S2   = 3'd3,
      ST_S3   = 3'd4,
      ST_S4   = 3'd5,
      ST_HALT = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      CLS_RTYPE = 3'd0,
      CLS_LW    = 3'd1,
      CLS_SW    = 3'd2,
      CLS_BEQ   = 3'd3,
      CLS_J     = 3'd4,
      CLS_ILL   = 3'd5
   } cls_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   // One-hot phase strobe vector {P4..P0} for a state; IDLE/HALT give zero.
   function automatic logic [4:0] phase_onehot(input state_e s);
      logic [4:0] v;
      v = 5'b00000;
      case (s)
         ST_S0:   v = 5'b00001;
         ST_S1:   v = 5'b00010;
         ST_S2:   v = 5'b00100;
         ST_S3:   v = 5'b01000;
         ST_S4:   v = 5'b10000;
         default: v = 5'b00000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: (Op, IRFunc) -> instruction class.
module instr_class_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] Op,
   input  logic [5:0] IRFunc,
   output cls_e       cls
);

   // Map the opcode (and funct for R-type) onto a class; unknowns are ILL.
   always_comb begin
      cls = CLS_ILL;
      case (Op)
         OP_RTYPE: begin
            case (IRFunc)
               F_ADD, F_SUB, F_AND, F_OR, F_SLT: cls = CLS_RTYPE;
               default:                          cls = CLS_ILL;
            endcase
         end
         OP_LW:   cls = CLS_LW;
         OP_SW:   cls = CLS_SW;
         OP_BEQ:  cls = CLS_BEQ;
         OP_J:    cls = CLS_J;
         default: cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/mc_phase_sequencer.sv
// Multi-cycle phase sequencer: walks each instruction through its IF/ID/EX/
// MEM/WB phases, stalls on memory, halts on illegal encodings and counts
// retired instructions.
module mc_phase_sequencer
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             clr,
   input  logic             run,
   input  logic             mem_ready,
   input  logic [5:0]       Op,
   input  logic [5:0]       IRFunc,
   output logic             P0,
   output logic             P1,
   output logic             P2,
   output logic             P3,
   output logic             P4,
   output logic             P,
   output logic             illegal,
   output logic             retire,
   output logic [CNT_W-1:0] retire_count
);

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d;
   cls_e             cls_dec;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [4:0]       phase_q;
   logic             busy_q;
   logic             last_phase;

   instr_class_decode u_decode (
      .Op     (Op),
      .IRFunc (IRFunc),
      .cls    (cls_dec)
   );

   // Next-state logic; last_phase marks the final cycle of an instruction's
   // path, which is also the retire strobe. Op/IRFunc are only looked at in S1.
   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      illegal_d  = illegal_q;
      last_phase = 1'b0;
      case (state_q)
         ST_IDLE: if (run) state_d = ST_S0;
         ST_S0:   if (mem_ready) state_d = ST_S1;
         ST_S1: begin
            cls_d = cls_dec;
            if (cls_dec == CLS_ILL) begin
               state_d   = ST_HALT;
               illegal_d = 1'b1;
            end else if (cls_dec == CLS_J) begin
               last_phase = 1'b1;
            end else begin
               state_d = ST_S2;
            end
         end
         ST_S2: begin
            case (cls_q)
               CLS_BEQ:   last_phase = 1'b1;
               CLS_RTYPE: state_d = ST_S4;
               default:   state_d = ST_S3;
            endcase
         end
         ST_S3: begin
            if (mem_ready) begin
               if (cls_q == CLS_SW) last_phase = 1'b1;
               else                 state_d = ST_S4;
            end
         end
         ST_S4:   last_phase = 1'b1;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
      // Instruction boundary: run decides between the next fetch and IDLE.
      if (last_phase) state_d = run ? ST_S0 : ST_IDLE;
      count_d = count_q + {{(CNT_W-1){1'b0}}, last_phase};
   end

   // State, class, sticky flag, counter and registered phase strobes.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_IDLE;
         cls_q     <= CLS_ILL;
         illegal_q <= 1'b0;
         count_q   <= '0;
         phase_q   <= 5'b00000;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
         phase_q   <= phase_onehot(state_d);
         busy_q    <= |phase_onehot(state_d);
      end
   end

   assign P0           = phase_q[0];
   assign P1           = phase_q[1];
   assign P2           = phase_q[2];
   assign P3           = phase_q[3];
   assign P4           = phase_q[4];
   assign P            = busy_q;
   assign illegal      = illegal_q;
   assign retire       = last_phase;
   assign retire_count = count_q;

endmodule

// File: tb/tb_mc_phase_sequencer.sv
// Self-checking bench for mc_phase_sequencer: directed scenarios followed by
// randomized instruction streams, compared cycle by cycle against a path model.
module tb_mc_phase_sequencer;

   localparam int TB_CNT_W = 4;

   logic                clk;
   logic                clr;
   logic                run;
   logic                mem_ready;
   logic [5:0]          Op;
   logic [5:0]          IRFunc;
   logic                P0, P1, P2, P3, P4, P;
   logic                illegal;
   logic                retire;
   logic [TB_CNT_W-1:0] retire_count;

   int n_vec;
   int n_err;
   int exp_count;
   bit exp_ill;

   mc_phase_sequencer #(.CNT_W(TB_CNT_W)) dut (
      .clk          (clk),
      .clr          (clr),
      .run          (run),
      .mem_ready    (mem_ready),
      .Op           (Op),
      .IRFunc       (IRFunc),
      .P0           (P0),
      .P1           (P1),
      .P2           (P2),
      .P3           (P3),
      .P4           (P4),
      .P            (P),
      .illegal      (illegal),
      .retire       (retire),
      .retire_count (retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Class number: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 J, 5 ILL.
   function automatic int ref_class(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00)
         return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) ? 0 : 5;
      if (op == 6'h23) return 1;
      if (op == 6'h2B) return 2;
      if (op == 6'h04) return 3;
      if (op == 6'h02) return 4;
      return 5;
   endfunction

   // Set of phases visited by each class, bit n = phase Sn.
   function automatic logic [4:0] ref_path(input int cls);
      case (cls)
         0:       return 5'b10111;
         1:       return 5'b11111;
         2:       return 5'b01111;
         3:       return 5'b00111;
         default: return 5'b00011;
      endcase
   endfunction

   task automatic check_cycle(input string tag, input int ph, input bit ret);
      int expv;
      expv = (ph < 0) ? 0 : (1 << ph);
      check_val({tag, "_phase"}, 32'({P4, P3, P2, P1, P0}), 32'(expv));
      check_val({tag, "_busy"}, 32'(P), 32'(ph >= 0));
      check_val({tag, "_retire"}, 32'(retire), 32'(ret));
      check_val({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
      check_val({tag, "_count"}, 32'(retire_count), 32'(exp_count % (1 << TB_CNT_W)));
   endtask

   // Assert clr for one cycle starting mid-cycle; verify the cleared state.
   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      run = 1'b0;
      exp_count = 0;
      exp_ill = 1'b0;
      #1;
      check_cycle("clr", -1, 1'b0);
   endtask

   // n IDLE cycles with run raised in the last one so S0 follows.
   task automatic idle_then_go(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         run = (k == n - 1);
         mem_ready = 1'($urandom);
         Op = 6'($urandom);
         IRFunc = 6'($urandom);
         #1;
         check_cycle("idle", -1, 1'b0);
      end
   endtask

   // One instruction, starting with the cycle in which S0 is entered.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int s0s,
                            input int s3s, input bit run_after, input bit abort_s3,
                            input int halt_cycles, output bit go_next);
      int ph[$];
      bit mr[$];
      bit rt[$];
      int cls;
      int lastp;
      logic [4:0] path;
      cls = ref_class(op, fn);
      path = ref_path(cls);
      lastp = 0;
      for (int p = 0; p < 5; p++) if (path[p]) lastp = p;
      for (int p = 0; p < 5; p++) begin
         if (path[p]) begin
            if (p == 0 || p == 3) begin
               for (int s = 0; s < ((p == 0) ? s0s : s3s); s++) begin
                  ph.push_back(p); mr.push_back(1'b0); rt.push_back(1'b0);
               end
               ph.push_back(p); mr.push_back(1'b1);
            end else begin
               ph.push_back(p); mr.push_back(1'($urandom));
            end
            rt.push_back(p == lastp && cls != 5);
         end
      end
      go_next = 1'b0;
      for (int i = 0; i < ph.size(); i++) begin
         @(posedge clk); #1;
         mem_ready = mr[i];
         run = (i == ph.size() - 1) ? run_after : 1'($urandom);
         Op = (ph[i] == 1) ? op : 6'($urandom);
         IRFunc = (ph[i] == 1) ? fn : 6'($urandom);
         #1;
         check_cycle("instr", ph[i], rt[i]);
         if (rt[i]) exp_count++;
         if (abort_s3 && ph[i] == 3 && !mr[i]) begin
            do_clr();
            return;
         end
      end
      if (cls == 5) begin
         exp_ill = 1'b1;
         for (int h = 0; h < halt_cycles; h++) begin
            @(posedge clk); #1;
            run = 1'($urandom);
            mem_ready = 1'($urandom);
            Op = 6'($urandom);
            IRFunc = 6'($urandom);
            #1;
            check_cycle("halt", -1, 1'b0);
         end
         do_clr();
         return;
      end
      go_next = run_after;
   endtask

   initial begin
      bit go;
      int c;
      logic [5:0] op, fn;
      logic [5:0] rfun [5];
      logic [5:0] ops [5];
      rfun[0] = 6'h20; rfun[1] = 6'h22; rfun[2] = 6'h24; rfun[3] = 6'h25; rfun[4] = 6'h2A;
      ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h02;
      n_vec = 0; n_err = 0; exp_count = 0; exp_ill = 1'b0;
      clr = 1'b1; run = 1'b0; mem_ready = 1'b0; Op = 6'h00; IRFunc = 6'h00;
      repeat (2) @(posedge clk);
      #1;
      do_clr();

      // Single J.
      idle_then_go(2);
      run_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, 0, go);
      // LW with 2 S0 and 3 S3 stalls, then back-to-back R-type SUB, run dropped.
      idle_then_go(1);
      run_instr(6'h23, 6'h00, 2, 3, 1'b1, 1'b0, 0, go);
      run_instr(6'h00, 6'h22, 0, 0, 1'b0, 1'b0, 0, go);
      // Illegal funct: HALT held 20 cycles until clr.
      idle_then_go(2);
      run_instr(6'h00, 6'h21, 0, 0, 1'b1, 1'b0, 20, go);
      // Reset mid-LW while stalled in S3, then a clean restart.
      idle_then_go(1);
      run_instr(6'h23, 6'h00, 0, 4, 1'b1, 1'b1, 0, go);
      idle_then_go(1);
      run_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, 0, go);
      // Counter wrap: 17 back-to-back BEQs from zero.
      do_clr();
      idle_then_go(1);
      for (int k = 0; k < 17; k++)
         run_instr(6'h04, 6'h00, 0, 0, (k < 16), 1'b0, 0, go);
      @(posedge clk); #1;
      run = 1'b0;
      #1;
      check_val("wrap_count", 32'(retire_count), 32'd1);
      check_val("wrap_idle", 32'(P), 32'd0);

      // Randomized instruction stream.
      go = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (!go) idle_then_go($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) begin
            do begin
               op = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
               fn = 6'($urandom);
            end while (ref_class(op, fn) != 5);
         end else begin
            c = $urandom_range(0, 4);
            op = ops[c];
            fn = (c == 0) ? rfun[$urandom_range(0, 4)] : 6'($urandom);
         end
         run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), ($urandom_range(0, 15) == 0), $urandom_range(1, 4), go);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
